// File: rtl/flow_speed_pkg.sv
// Shared types and helpers for the flow-speed pipeline: table entry layout,
// width constants, mod-2^32 serial compare and saturating age.
package flow_speed_pkg;

    localparam int C_ID_WIDTH   = 23;
    localparam int C_IDX_BITS   = 6;
    localparam int C_TIME_WIDTH = 64;
    localparam int C_SQN_WIDTH  = 32;
    localparam int C_TAG_WIDTH  = C_ID_WIDTH - C_IDX_BITS;
    localparam int C_DEPTH      = 1 << C_IDX_BITS;

    typedef struct packed {
        logic                    vld;
        logic [C_TAG_WIDTH-1:0]  tag;
        logic [C_SQN_WIDTH-1:0]  sqn;
        logic [C_TIME_WIDTH-1:0] ts;
    } entry_t;

    // True when a is strictly ahead of b in mod-2^32 sequence space.
    function automatic logic sqn_after(input logic [C_SQN_WIDTH-1:0] a,
                                       input logic [C_SQN_WIDTH-1:0] b);
        logic [C_SQN_WIDTH-1:0] d;
        d = a - b;
        return (d != '0) && !d[C_SQN_WIDTH-1];
    endfunction

    // now - t_then, clamped to the largest value representable in rtt_w bits.
    function automatic logic [C_TIME_WIDTH-1:0] sat_age(input logic [C_TIME_WIDTH-1:0] now,
                                                        input logic [C_TIME_WIDTH-1:0] t_then,
                                                        input int unsigned rtt_w);
        logic [C_TIME_WIDTH-1:0] diff;
        logic [C_TIME_WIDTH-1:0] lim;
        diff = now - t_then;
        if (rtt_w >= C_TIME_WIDTH) begin
            return diff;
        end
        lim = (C_TIME_WIDTH'(1) << rtt_w) - C_TIME_WIDTH'(1);
        return (diff > lim) ? lim : diff;
    endfunction

endpackage

// File: rtl/flow_rtt_table.sv
// Flop array of outstanding egress samples: two combinational read ports and
// a commit that applies the ingress clear before the egress write.
module flow_rtt_table
    import flow_speed_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [C_IDX_BITS-1:0] rd_idx_0,
    input  logic [C_IDX_BITS-1:0] rd_idx_1,
    output entry_t                rd_entry_0,
    output entry_t                rd_entry_1,
    input  logic                  clr_en,
    input  logic [C_IDX_BITS-1:0] clr_idx,
    input  logic                  wr_en,
    input  logic [C_IDX_BITS-1:0] wr_idx,
    input  entry_t                wr_entry
);

    entry_t table_q [C_DEPTH];
    entry_t table_d [C_DEPTH];

    assign rd_entry_0 = table_q[rd_idx_0];
    assign rd_entry_1 = table_q[rd_idx_1];

    // Write after clear so an egress re-arm wins over a same-slot ingress clear.
    always_comb begin
        for (int i = 0; i < C_DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        if (clr_en) begin
            table_d[clr_idx].vld = 1'b0;
        end
        if (wr_en) begin
            table_d[wr_idx] = wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

endmodule

// File: rtl/flow_rtt_match.sv
// Pairs egress samples with covering ingress acks per flow slot and emits RTTs.
// Optional RTT_MINMAX_EN adds running rtt_min / rtt_max outputs.
module flow_rtt_match
    import flow_speed_pkg::*;
#(
    parameter int          C_RTT_WIDTH = 32,
    parameter int unsigned C_TIMEOUT   = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid_0,
    input  logic [C_TIME_WIDTH-1:0] in_time_0,
    input  logic [C_SQN_WIDTH-1:0]  in_sqn_0,
    input  logic [C_ID_WIDTH-1:0]   in_id_0,
    input  logic                    in_valid_1,
    input  logic [C_TIME_WIDTH-1:0] in_time_1,
    input  logic [C_SQN_WIDTH-1:0]  in_sqn_1,
    input  logic [C_ID_WIDTH-1:0]   in_id_1,
    output logic                    out_valid,
    output logic [C_ID_WIDTH-1:0]   out_id,
    output logic [C_RTT_WIDTH-1:0]  out_rtt,
    output logic                    out_timeout,
`ifdef RTT_MINMAX_EN
    output logic [C_RTT_WIDTH-1:0]  rtt_min,
    output logic [C_RTT_WIDTH-1:0]  rtt_max,
`endif
    output logic [31:0]             cnt_samples,
    output logic [31:0]             cnt_matches,
    output logic [31:0]             cnt_collisions
);

    localparam logic [C_TIME_WIDTH-1:0] TIMEOUT_T = C_TIME_WIDTH'(C_TIMEOUT);

    logic [C_IDX_BITS-1:0]   idx_0, idx_1;
    logic [C_TAG_WIDTH-1:0]  tag_0, tag_1;
    entry_t                  rd_entry_0, rd_entry_1, eg_entry, wr_entry;
    logic [C_TIME_WIDTH-1:0] age_0, age_1;
    logic                    hit_1, stale_1, match_1, clr_en, free_0, wr_en;

    logic                   out_valid_q, out_valid_d;
    logic [C_ID_WIDTH-1:0]  out_id_q, out_id_d;
    logic [C_RTT_WIDTH-1:0] out_rtt_q, out_rtt_d;
    logic                   out_timeout_q, out_timeout_d;
    logic [31:0]            cnt_samples_q, cnt_samples_d;
    logic [31:0]            cnt_matches_q, cnt_matches_d;
    logic [31:0]            cnt_collisions_q, cnt_collisions_d;

    assign idx_0 = in_id_0[C_IDX_BITS-1:0];
    assign idx_1 = in_id_1[C_IDX_BITS-1:0];
    assign tag_0 = in_id_0[C_ID_WIDTH-1:C_IDX_BITS];
    assign tag_1 = in_id_1[C_ID_WIDTH-1:C_IDX_BITS];

    flow_rtt_table u_table (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_0   (idx_0),
        .rd_idx_1   (idx_1),
        .rd_entry_0 (rd_entry_0),
        .rd_entry_1 (rd_entry_1),
        .clr_en     (clr_en),
        .clr_idx    (idx_1),
        .wr_en      (wr_en),
        .wr_idx     (idx_0),
        .wr_entry   (wr_entry)
    );

    always_comb begin
        age_1   = in_time_1 - rd_entry_1.ts;
        hit_1   = in_valid_1 && rd_entry_1.vld && (rd_entry_1.tag == tag_1);
        stale_1 = age_1 > TIMEOUT_T;
        match_1 = hit_1 && !stale_1 && sqn_after(in_sqn_1, rd_entry_1.sqn);
        clr_en  = (hit_1 && stale_1) || match_1;

        // Egress sees the slot as it will be after this cycle's ingress clear.
        eg_entry = rd_entry_0;
        if (clr_en && (idx_1 == idx_0)) begin
            eg_entry.vld = 1'b0;
        end
        age_0  = in_time_0 - eg_entry.ts;
        free_0 = !eg_entry.vld || (age_0 > TIMEOUT_T);
        wr_en  = in_valid_0 && free_0;

        wr_entry.vld = 1'b1;
        wr_entry.tag = tag_0;
        wr_entry.sqn = in_sqn_0;
        wr_entry.ts  = in_time_0;

        out_valid_d   = clr_en;
        out_timeout_d = hit_1 && stale_1;
        out_id_d      = clr_en ? in_id_1 : '0;
        out_rtt_d     = match_1 ? C_RTT_WIDTH'(sat_age(in_time_1, rd_entry_1.ts, C_RTT_WIDTH)) : '0;

        cnt_samples_d    = cnt_samples_q + {31'd0, wr_en};
        cnt_matches_d    = cnt_matches_q + {31'd0, match_1};
        cnt_collisions_d = cnt_collisions_q + {31'd0, in_valid_0 && !free_0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            out_id_q         <= '0;
            out_rtt_q        <= '0;
            out_timeout_q    <= 1'b0;
            cnt_samples_q    <= '0;
            cnt_matches_q    <= '0;
            cnt_collisions_q <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_id_q         <= out_id_d;
            out_rtt_q        <= out_rtt_d;
            out_timeout_q    <= out_timeout_d;
            cnt_samples_q    <= cnt_samples_d;
            cnt_matches_q    <= cnt_matches_d;
            cnt_collisions_q <= cnt_collisions_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_id         = out_id_q;
    assign out_rtt        = out_rtt_q;
    assign out_timeout    = out_timeout_q;
    assign cnt_samples    = cnt_samples_q;
    assign cnt_matches    = cnt_matches_q;
    assign cnt_collisions = cnt_collisions_q;

`ifdef RTT_MINMAX_EN
    logic [C_RTT_WIDTH-1:0] rtt_min_q, rtt_min_d;
    logic [C_RTT_WIDTH-1:0] rtt_max_q, rtt_max_d;

    always_comb begin
        rtt_min_d = rtt_min_q;
        rtt_max_d = rtt_max_q;
        if (match_1) begin
            if (out_rtt_d < rtt_min_q) rtt_min_d = out_rtt_d;
            if (out_rtt_d > rtt_max_q) rtt_max_d = out_rtt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rtt_min_q <= '1;
            rtt_max_q <= '0;
        end else begin
            rtt_min_q <= rtt_min_d;
            rtt_max_q <= rtt_max_d;
        end
    end

    assign rtt_min = rtt_min_q;
    assign rtt_max = rtt_max_q;
`endif

endmodule

// File: tb/tb_flow_rtt_match.sv
// Bench for flow_rtt_match: directed vector table, reset sequence, then random
// traffic against a per-flow dictionary model. Define RTT_MINMAX_EN to cover min/max.
module tb_flow_rtt_match;
    import flow_speed_pkg::*;

    localparam int          RTT_W   = 32;
    localparam int unsigned TIMEOUT = 100;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid_0 = 1'b0, in_valid_1 = 1'b0;
    logic [C_TIME_WIDTH-1:0] in_time_0 = '0, in_time_1 = '0;
    logic [31:0]             in_sqn_0 = '0, in_sqn_1 = '0;
    logic [C_ID_WIDTH-1:0]   in_id_0 = '0, in_id_1 = '0;
    logic                    out_valid, out_timeout;
    logic [C_ID_WIDTH-1:0]   out_id;
    logic [RTT_W-1:0]        out_rtt;
    logic [31:0]             cnt_samples, cnt_matches, cnt_collisions;
`ifdef RTT_MINMAX_EN
    logic [RTT_W-1:0]        rtt_min, rtt_max;
`endif

    flow_rtt_match #(.C_RTT_WIDTH(RTT_W), .C_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_0     (in_valid_0),
        .in_time_0      (in_time_0),
        .in_sqn_0       (in_sqn_0),
        .in_id_0        (in_id_0),
        .in_valid_1     (in_valid_1),
        .in_time_1      (in_time_1),
        .in_sqn_1       (in_sqn_1),
        .in_id_1        (in_id_1),
        .out_valid      (out_valid),
        .out_id         (out_id),
        .out_rtt        (out_rtt),
        .out_timeout    (out_timeout),
`ifdef RTT_MINMAX_EN
        .rtt_min        (rtt_min),
        .rtt_max        (rtt_max),
`endif
        .cnt_samples    (cnt_samples),
        .cnt_matches    (cnt_matches),
        .cnt_collisions (cnt_collisions)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a dictionary of outstanding samples keyed by full flow id,
    // with the rule that a slot (id mod 64) holds at most one flow at a time.
    bit                 m_armed [int];
    longint unsigned    m_ts    [int];
    int unsigned        m_sqn   [int];
    int unsigned        m_samples, m_matches, m_colls;
    longint unsigned    m_min, m_max;
    bit                 e_valid, e_to;
    int unsigned        e_id;
    longint unsigned    e_rtt;

    function automatic int slot_owner(input int unsigned id);
        foreach (m_armed[k]) begin
            if (m_armed[k] && (k % C_DEPTH) == (id % C_DEPTH)) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_armed.delete(); m_ts.delete(); m_sqn.delete();
        m_samples = 0; m_matches = 0; m_colls = 0;
        m_min = 64'hFFFF_FFFF; m_max = 0;
        e_valid = 0; e_to = 0; e_id = 0; e_rtt = 0;
    endtask

    task automatic model_step(input bit v0, input int unsigned id0, input int unsigned s0, input longint unsigned t0,
                              input bit v1, input int unsigned id1, input int unsigned s1, input longint unsigned t1);
        int owner;
        longint unsigned age;
        e_valid = 0; e_to = 0; e_id = 0; e_rtt = 0;
        if (v1) begin
            owner = slot_owner(id1);
            if (owner == int'(id1)) begin
                age = t1 - m_ts[owner];
                if (age > TIMEOUT) begin
                    e_valid = 1; e_to = 1; e_id = id1;
                    m_armed[owner] = 0;
                end else if (int'(s1 - m_sqn[owner]) > 0) begin
                    e_valid = 1; e_id = id1;
                    e_rtt = (age > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : age;
                    m_armed[owner] = 0;
                    m_matches++;
                    if (e_rtt < m_min) m_min = e_rtt;
                    if (e_rtt > m_max) m_max = e_rtt;
                end
            end
        end
        if (v0) begin
            owner = slot_owner(id0);
            if (owner < 0 || (t0 - m_ts[owner]) > TIMEOUT) begin
                if (owner >= 0) m_armed[owner] = 0;
                m_armed[id0] = 1; m_ts[id0] = t0; m_sqn[id0] = s0;
                m_samples++;
            end else begin
                m_colls++;
            end
        end
    endtask

    // driver: apply one cycle of inputs, step the model, sample after the edge
    task automatic drive(input bit v0, input int unsigned id0, input int unsigned s0, input longint unsigned t0,
                         input bit v1, input int unsigned id1, input int unsigned s1, input longint unsigned t1);
        in_valid_0 = v0; in_id_0 = C_ID_WIDTH'(id0); in_sqn_0 = s0; in_time_0 = t0;
        in_valid_1 = v1; in_id_1 = C_ID_WIDTH'(id1); in_sqn_1 = s1; in_time_1 = t1;
        model_step(v0, id0, s0, t0, v1, id1, s1, t1);
        @(posedge clk);
        #1;
        in_valid_0 = 0; in_valid_1 = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(e_valid));
        if (e_valid) begin
            check({tag, ".id"},      64'(out_id),      64'(e_id));
            check({tag, ".rtt"},     64'(out_rtt),     e_rtt);
            check({tag, ".timeout"}, 64'(out_timeout), 64'(e_to));
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".cnt_samples"},    64'(cnt_samples),    64'(m_samples));
        check({tag, ".cnt_matches"},    64'(cnt_matches),    64'(m_matches));
        check({tag, ".cnt_collisions"}, 64'(cnt_collisions), 64'(m_colls));
`ifdef RTT_MINMAX_EN
        check({tag, ".rtt_min"}, 64'(rtt_min), m_min);
        check({tag, ".rtt_max"}, 64'(rtt_max), m_max);
`endif
    endtask

    typedef struct {
        bit              v0;
        int unsigned     id0;
        int unsigned     s0;
        longint unsigned t0;
        bit              v1;
        int unsigned     id1;
        int unsigned     s1;
        longint unsigned t1;
        bit              x_valid;
        int unsigned     x_id;
        int unsigned     x_rtt;
        bit              x_to;
    } vec_t;

    vec_t vecs [21];

    initial begin
        longint unsigned now;
        model_reset();

        vecs[0]  = '{1, 5, 100, 10,            0, 0, 0, 0,          0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0,               1, 5, 101, 40,       1, 5, 30, 0};
        vecs[2]  = '{1, 5, 100, 50,            0, 0, 0, 0,          0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0,               1, 5, 100, 60,       0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0,               1, 5, 101, 70,       1, 5, 20, 0};
        vecs[5]  = '{1, 6, 32'hFFFF_FFF0, 100, 0, 0, 0, 0,          0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0,               1, 6, 1, 110,        1, 6, 10, 0};
        vecs[7]  = '{1, 5, 7, 200,             0, 0, 0, 0,          0, 0, 0, 0};
        vecs[8]  = '{1, 5, 9, 210,             0, 0, 0, 0,          0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0,               1, 69, 100, 220,     0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0,               1, 5, 8, 230,        1, 5, 30, 0};
        vecs[11] = '{1, 7, 1, 300,             0, 0, 0, 0,          0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0,               1, 7, 2, 401,        1, 7, 0, 1};
        vecs[13] = '{0, 0, 0, 0,               1, 7, 2, 402,        0, 0, 0, 0};
        vecs[14] = '{1, 8, 1, 500,             0, 0, 0, 0,          0, 0, 0, 0};
        vecs[15] = '{1, 8, 2, 650,             0, 0, 0, 0,          0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0,               1, 8, 2, 700,        0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0,               1, 8, 3, 700,        1, 8, 50, 0};
        vecs[18] = '{1, 3, 10, 800,            0, 0, 0, 0,          0, 0, 0, 0};
        vecs[19] = '{1, 3, 20, 900,            1, 3, 11, 900,       1, 3, 100, 0};
        vecs[20] = '{0, 0, 0, 0,               1, 3, 21, 950,       1, 3, 50, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid",   64'(out_valid),   0);
        check("reset.out_timeout", 64'(out_timeout), 0);
        check("reset.out_id",      64'(out_id),      0);
        check("reset.out_rtt",     64'(out_rtt),     0);
        check_counters("reset");
        reset = 0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].v0, vecs[i].id0, vecs[i].s0, vecs[i].t0,
                  vecs[i].v1, vecs[i].id1, vecs[i].s1, vecs[i].t1);
            check($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].x_valid));
            if (vecs[i].x_valid) begin
                check($sformatf("vec%0d.id", i),      64'(out_id),      64'(vecs[i].x_id));
                check($sformatf("vec%0d.rtt", i),     64'(out_rtt),     64'(vecs[i].x_rtt));
                check($sformatf("vec%0d.timeout", i), 64'(out_timeout), 64'(vecs[i].x_to));
            end
            if (i == 1) begin
                check("first.cnt_samples", 64'(cnt_samples), 1);
                check("first.cnt_matches", 64'(cnt_matches), 1);
            end
        end
        check("dir.cnt_samples",    64'(cnt_samples),    9);
        check("dir.cnt_matches",    64'(cnt_matches),    7);
        check("dir.cnt_collisions", 64'(cnt_collisions), 1);
        check_counters("dir");

        // Reset mid-stream discards the armed sample on flow 9.
        drive(1, 9, 1, 1000, 0, 0, 0, 0);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        check("midreset.out_valid", 64'(out_valid), 0);
        check_counters("midreset");
        drive(0, 0, 0, 0, 1, 9, 2, 1010);
        check("midreset.ack_ignored", 64'(out_valid), 0);
        check_outputs("midreset.model");

        // Random traffic on 8 slots x 2 tags with a shared, slowly advancing clock.
        now = 2000;
        for (int c = 0; c < 3000; c++) begin
            bit v0, v1;
            int unsigned id0, id1, s0, s1;
            now += 64'($urandom_range(0, 12));
            v0  = ($urandom_range(0, 2) == 0);
            v1  = ($urandom_range(0, 1) == 0);
            id0 = $urandom_range(0, 7) + C_DEPTH * $urandom_range(0, 1);
            id1 = ($urandom_range(0, 3) == 0) ? id0 : $urandom_range(0, 7) + C_DEPTH * $urandom_range(0, 1);
            s0  = 32'hFFFF_FFF8 + $urandom_range(0, 16);
            s1  = 32'hFFFF_FFF8 + $urandom_range(0, 16);
            drive(v0, id0, s0, now, v1, id1, s1, now - 64'($urandom_range(0, 3)));
            check_outputs($sformatf("rand%0d", c));
        end
        check_counters("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flow_rtt_match.md
Name: flow_rtt_match

Overview:
- Downstream consumer of the two-path lookup stage. Takes per-packet lookup results from both paths: path 0 is egress (time, sqn, flow id) and path 1 is ingress (time, ack number in the sqn field, flow id).
- Keeps one outstanding egress sample per flow slot. When an ingress ack covers the sample, it emits a per-flow RTT.
- Feeds the flow-speed statistics/report stage.

Parameters:
- C_ID_WIDTH, 23, flow id width from the lookup stage.
- C_IDX_BITS, 6, table index bits; index = id[C_IDX_BITS-1:0], tag = remaining upper id bits.
- C_TIME_WIDTH, 64, input timestamp width.
- C_RTT_WIDTH, 32, output RTT width; results saturate.
- C_TIMEOUT, 1000000, sample age in cycles beyond which an entry is stale.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid_0  in  1  egress result strobe
- in_time_0  in  C_TIME_WIDTH  egress timestamp
- in_sqn_0  in  32  egress sequence number
- in_id_0  in  C_ID_WIDTH  egress flow id
- in_valid_1  in  1  ingress result strobe
- in_time_1  in  C_TIME_WIDTH  ingress timestamp
- in_sqn_1  in  32  ingress ack number
- in_id_1  in  C_ID_WIDTH  ingress flow id
- out_valid  out  1  RTT result strobe
- out_id  out  C_ID_WIDTH  flow id of the result
- out_rtt  out  C_RTT_WIDTH  RTT in cycles, saturated
- out_timeout  out  1  qualifies out_valid: 1 = sample expired, out_rtt = 0
- cnt_samples  out  32  egress samples armed
- cnt_matches  out  32  RTTs emitted with out_timeout = 0
- cnt_collisions  out  32  egress arms refused because the slot was occupied by a live entry

Behaviour:
- Table: 2^C_IDX_BITS entries in flops. Each entry holds {vld, tag, sqn, time}.
- Reset: all vld = 0. out_valid, out_timeout, out_id, out_rtt = 0. All counters = 0. Reset mid-operation discards every armed sample.
- Both paths are evaluated every cycle against pre-cycle table contents. Table updates commit at the clock edge. Output latency is 1 cycle from the input strobe.
- Ingress (valid_1), with e = entry[idx1]:
  - e.vld, tag match, age = in_time_1 - e.time > C_TIMEOUT: emit out_valid = 1, out_timeout = 1, out_rtt = 0; clear vld.
  - e.vld, tag match, not stale, and $signed(in_sqn_1 - e.sqn) > 0 (mod-2^32 serial compare): emit out_rtt = min(age, 2^C_RTT_WIDTH - 1), out_timeout = 0; clear vld; cnt_matches++.
  - Otherwise (invalid, tag mismatch, ack not beyond sqn): no output, no change.
- Egress (valid_0), with e' = entry[idx0] after any same-cycle ingress clear:
  - If !e'.vld, or e'.vld and (in_time_0 - e'.time) > C_TIMEOUT: write {1, tag0, in_sqn_0, in_time_0}; cnt_samples++.
  - Otherwise: cnt_collisions++ and the entry is kept.
  - A stale overwrite does not emit a timeout result.
- Same index on both paths in one cycle: ingress match/clear first, then egress may re-arm the same slot.
- Equal sqn/ack (difference 0) is not a match.
- Serial compare wraps correctly across 2^32.
- Counters wrap at 2^32.
- No backpressure: the downstream stage must accept one result per cycle.

Optional Feature:
- RTT_MINMAX_EN defined: adds outputs rtt_min and rtt_max, each C_RTT_WIDTH bits, updated on non-timeout results. Reset values: rtt_min = all-ones, rtt_max = 0. A result updates both registers on the same edge as out_valid.
- RTT_MINMAX_EN undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Shared package `flow_speed_pkg`: entry struct (vld/tag/sqn/time), width localparams derived from C_ID_WIDTH/C_IDX_BITS, serial-compare function, saturating-subtract function.
- Sub-module `flow_rtt_table`: the flop array with one combinational read per path, ordered clear-then-write commit, and synchronous reset clear. The top level holds the decision logic, output registers and counters.

Test Plan:
- Egress id=5, sqn=100, t=10; ingress id=5, ack=101, t=40 -> next cycle out_valid=1, out_id=5, out_rtt=30, out_timeout=0; cnt_samples=1, cnt_matches=1.
- Egress id=5, sqn=100; ingress id=5, ack=100 -> no output. Then ack=0x0000_0001 after sqn=0xFFFF_FFF0 armed -> match (wrap).
- Egress id=5 twice, t=10 and t=20 -> second refused, cnt_collisions=1; a later ack yields rtt measured from t=10.
- Ingress id=5+64 (same idx, different tag) with ack > sqn -> no output, entry stays armed.
- C_TIMEOUT=100: egress t=0, ingress t=200 -> out_timeout=1, out_rtt=0, slot freed. Separately, egress t=0 then egress t=150 same slot -> overwrite, no collision count.
- Same cycle: ingress match on idx 3 plus egress on idx 3 -> RTT emitted and new sample armed. Assert reset mid-stream -> outputs 0, later ack on that flow produces nothing.
